regfile_master: RTL

REGFILE_MASTER -- requirements
Module: regfile_master

---
 rtl/regfile_master.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_master.sv
// regfile_master: command FSM that reads, writes, swaps and range-clears an external register file
module regfile_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] readReg1,
  output logic [ADDR_W-1:0] readReg2,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              RegWrite,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2
);
  typedef enum logic [2:0] {IDLE, RD, WR, SW_RD, SW_W1, SW_W2, CLR, RESP} state_t;
  state_t state;
  logic [ADDR_W-1:0] ra, rb, cnt;
  // command sequencer; every output is registered and the CLEAR error flag is decided at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
      readReg1 <= '0;
      readReg2 <= '0;
      writeReg <= '0;
      writeData <= '0;
      RegWrite <= 1'b0;
      ra <= '0;
      rb <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          ra <= cmd_ra;
          rb <= cmd_rb;
          cmd_ready <= 1'b0;
          rsp_err <= 1'b0;
          case (cmd_op)
            2'b00: begin
              readReg1 <= cmd_ra;
              readReg2 <= cmd_rb;
              state <= RD;
            end
            2'b01: begin
              writeReg <= cmd_ra;
              writeData <= cmd_wdata;
              RegWrite <= 1'b1;
              state <= WR;
            end
            2'b10: begin
              readReg1 <= cmd_ra;
              readReg2 <= cmd_rb;
              state <= SW_RD;
            end
            default: begin
              cnt <= cmd_ra;
              writeReg <= cmd_ra;
              writeData <= '0;
              RegWrite <= (cmd_ra <= cmd_rb);
              rsp_err <= (cmd_ra > cmd_rb);
              state <= CLR;
            end
          endcase
        end
        RD: begin
          rsp_data1 <= data1;
          rsp_data2 <= data2;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        WR: begin
          RegWrite <= 1'b0;
          rsp_data1 <= writeData;
          rsp_data2 <= '0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        SW_RD: begin
          rsp_data1 <= data1;
          rsp_data2 <= data2;
          writeReg <= ra;
          writeData <= data2;
          RegWrite <= 1'b1;
          state <= SW_W1;
        end
        SW_W1: begin
          writeReg <= rb;
          writeData <= rsp_data1;
          state <= SW_W2;
        end
        SW_W2: begin
          RegWrite <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        CLR: if (rsp_err || cnt == rb) begin
          RegWrite <= 1'b0;
          rsp_data1 <= rsp_err ? '0 : DATA_W'(rb) - DATA_W'(ra) + DATA_W'(1);
          rsp_data2 <= '0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
          writeReg <= cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
